alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Multi-cycle datapath ALU for the microprogrammed CPU core. Replaces the single-cycle operand-latch ALU.
- Keeps the register-loaded operand model: A, B and carry-in are loaded from the shared data bus under LDDR1/LDDR2/LDCN.
- Adds a fully synchronous clocking scheme (no gated clocks), a start/busy/done handshake, and two iterative modes: unsigned multiply and unsigned divide.
- Results and flags are registered and held for the controller until the next completed operation.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be ≥4 and a multiple of 4.
- FLAG_W, 16, flag bus width. Must be ≥5.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data  input  WIDTH  shared data bus, source for A, B and CN loads.
- LDDR1  input  1  load A from data on the clk edge.
- LDDR2  input  1  load B from data on the clk edge.
- LDCN  input  1  load CN from data[0] on the clk edge.
- S  input  4  74181 function select.
- M  input  1  1 = logic, 0 = arithmetic (74181 semantics).
- mode  input  2  00 = ALU, 01 = MUL, 10 = DIV, 11 = reserved (treated as ALU).
- start  input  1  begin an operation; sampled only in IDLE.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; F, F_hi and flag are valid from this cycle on.
- F  output  WIDTH  result low word / quotient.
- F_hi  output  WIDTH  product high word / remainder; 0 in ALU mode.
- flag  output  FLAG_W  {zeros, DZ, V, N, Z, C} at bits [4:0].
- A, B  output  WIDTH  operand register contents.
- CN  output  1  carry-in register (1 = carry into LSB active).

Behaviour:
- Reset (async, rst_n=0):
  - A, B, CN, F, F_hi, flag = 0; busy = 0; done = 0; state = IDLE.
  - Any operation in flight is abandoned. No done is emitted after reset releases.
- Operand loads:
  - Synchronous on the clk edge, honoured only when busy=0. Ignored while busy.
  - LDDR1 and LDDR2 may both be active in the same cycle; both registers load the same data value.
- Operand capture:
  - start in IDLE snapshots the pre-edge values of A, B, CN, S, M and mode into internal working registers.
  - A load in the same cycle as start updates A/B/CN but does not affect that operation.
- States: IDLE, ALU, MUL, DIV, DONE.
  - IDLE → ALU, MUL or DIV on start.
  - ALU → DONE after 1 cycle.
  - MUL → DONE after WIDTH iterations.
  - DIV → DONE after WIDTH iterations. If the divisor is 0, DIV → DONE after 1 cycle.
  - DONE → IDLE unconditionally.
  - busy = 1 in ALU, MUL and DIV states.
  - done = 1 in DONE only. F, F_hi and flag update on the edge entering DONE.
- Latency (start sampled at edge t):
  - ALU: done at cycle t+2.
  - MUL and non-zero DIV: done at t+WIDTH+2.
  - DIV by zero: done at t+2.
  - start asserted in DONE is ignored. Earliest restart is the cycle after done.
- ALU mode:
  - F follows the 74181 active-high-data function table for S/M, cascaded across WIDTH/4 slices with ripple carry.
  - CN=1 adds 1 in arithmetic mode.
  - Key codes: S=1001,M=0 gives A+B+CN. S=0110,M=0 gives A−B−1+CN. S=1011,M=1 gives A&B. S=1110,M=1 gives A|B. S=0110,M=1 gives A^B.
  - C = carry out of MSB (arithmetic only; 0 when M=1).
  - V = signed overflow, defined for S=1001 and S=0110 with M=0; otherwise 0.
  - F_hi = 0.
- MUL mode:
  - Unsigned shift-add, one partial product per cycle.
  - {F_hi,F} = A×B (2·WIDTH bits).
  - C = (F_hi≠0); V = 0; N = 0.
- DIV mode:
  - Unsigned restoring division, one quotient bit per cycle.
  - F = A/B, F_hi = A mod B.
  - B=0: F = all ones, F_hi = A, DZ = 1.
  - C = V = N = 0.
- All modes:
  - Z = (F==0) in ALU and DIV modes; Z = ({F_hi,F}==0) in MUL mode.
  - N = F[WIDTH-1] in ALU mode.
  - DZ = 0 except for DIV by zero.
  - flag bits above bit 4 are always 0.
- F, F_hi and flag hold their values between operations, including during busy.

Test Plan:
- WIDTH=16. Load A=0x7FFF, B=0x0001, CN=0; S=1001, M=0, mode=00, start at t → done at t+2, F=0x8000, flag=0x000C.
- A=0xFFFF, B=0x0001, CN=0, add → F=0x0000, flag=0x0003. With CN=1 → F=0x0001, flag=0x0001.
- MUL A=0x1234, B=0x0100 → busy for 17 cycles, done at t+18, F=0x3400, F_hi=0x0012, flag=0x0001. LDDR1 pulsed mid-operation leaves A=0x1234.
- DIV A=1000, B=7 → F=0x008E, F_hi=0x0006, flag=0x0000, done at t+18. DIV A=0x0055, B=0 → done at t+2, F=0xFFFF, F_hi=0x0055, flag=0x0010.
- rst_n low during the 5th MUL cycle → busy=0, F=0, A=0 immediately. No done after release. A following ALU op completes normally.
- start with LDDR1 (data=0x0003) in the same cycle, A=0x0002, B=0x0001, add → F=0x0003 and A reads 0x0003. start during DONE → ignored, no second done.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle 74181-style ALU with iterative unsigned multiply and restoring divide.
// Latency from start: ALU and divide-by-zero 2 cycles, MUL/DIV WIDTH+2 cycles; operand loads are ignored while busy.
module alu_mc #(
    parameter int WIDTH  = 16,
    parameter int FLAG_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  data,
    input  logic              LDDR1,
    input  logic              LDDR2,
    input  logic              LDCN,
    input  logic [3:0]        S,
    input  logic              M,
    input  logic [1:0]        mode,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  F,
    output logic [WIDTH-1:0]  F_hi,
    output logic [FLAG_W-1:0] flag,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic              CN
);

    localparam int NSL = WIDTH / 4;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [2:0] {IDLE, ALU, MUL, DIV, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] wa, wb, hi, lo;
    logic             wcn, wm;
    logic [3:0]       ws;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] t1, t2, alu_f;
    logic [NSL:0]     c;
    logic [4:0]       sl;
    logic             alu_c, alu_v;
    logic [WIDTH:0]   mul_sum, div_tmp;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;

    function automatic logic [FLAG_W-1:0] pack_flag(input logic dz, input logic v,
                                                    input logic n, input logic z,
                                                    input logic cy);
        logic [FLAG_W-1:0] f;
        f      = '0;
        f[4:0] = {dz, v, n, z, cy};
        return f;
    endfunction

    assign busy = (state == ALU) || (state == MUL) || (state == DIV);
    assign done = (state == DONE);

    // 74181 internal terms: arithmetic is t1 + t2 + cn, logic is ~(t1 ^ t2)
    always_comb begin
        t1 = wa | (wb & {WIDTH{ws[0]}}) | (~wb & {WIDTH{ws[1]}});
        t2 = (wa & ~wb & {WIDTH{ws[2]}}) | (wa & wb & {WIDTH{ws[3]}});
        c     = '0;
        c[0]  = wcn;
        sl    = '0;
        alu_f = '0;
        for (int i = 0; i < NSL; i++) begin
            sl = {1'b0, t1[i*4 +: 4]} + {1'b0, t2[i*4 +: 4]} + {4'b0, c[i]};
            c[i+1]         = sl[4];
            alu_f[i*4 +: 4] = sl[3:0];
        end
        if (wm) begin
            alu_f = ~(t1 ^ t2);
        end
        alu_c = wm ? 1'b0 : c[NSL];
        alu_v = 1'b0;
        if (!wm && ws == 4'b1001) begin
            alu_v = (wa[WIDTH-1] == wb[WIDTH-1]) && (alu_f[WIDTH-1] != wa[WIDTH-1]);
        end else if (!wm && ws == 4'b0110) begin
            alu_v = (wa[WIDTH-1] != wb[WIDTH-1]) && (alu_f[WIDTH-1] != wa[WIDTH-1]);
        end
    end

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, wb} : '0);
        div_tmp = {hi, lo[WIDTH-1]};
        div_ge  = (div_tmp >= {1'b0, wb});
        div_sub = div_tmp[WIDTH-1:0] - wb;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (mode)
                        2'b01:   state_nx = MUL;
                        2'b10:   state_nx = DIV;
                        default: state_nx = ALU;
                    endcase
                end
            end
            ALU:     state_nx = DONE;
            MUL:     if (cnt == LAST) state_nx = DONE;
            DIV:     if (wb == '0 || cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A    <= '0;
            B    <= '0;
            CN   <= 1'b0;
            F    <= '0;
            F_hi <= '0;
            flag <= '0;
            wa   <= '0;
            wb   <= '0;
            wcn  <= 1'b0;
            ws   <= '0;
            wm   <= 1'b0;
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
        end else begin
            if (!busy) begin
                if (LDDR1) A  <= data;
                if (LDDR2) B  <= data;
                if (LDCN)  CN <= data[0];
            end
            case (state)
                IDLE: begin
                    // Snapshot uses pre-edge operands, so a same-cycle load does not leak in
                    if (start) begin
                        wa  <= A;
                        wb  <= B;
                        wcn <= CN;
                        ws  <= S;
                        wm  <= M;
                        hi  <= '0;
                        lo  <= A;
                        cnt <= '0;
                    end
                end
                ALU: begin
                    F    <= alu_f;
                    F_hi <= '0;
                    flag <= pack_flag(1'b0, alu_v, alu_f[WIDTH-1], alu_f == '0, alu_c);
                end
                MUL: begin
                    if (cnt != LAST) begin
                        {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
                        cnt      <= cnt + CW'(1);
                    end else begin
                        F    <= lo;
                        F_hi <= hi;
                        flag <= pack_flag(1'b0, 1'b0, 1'b0, {hi, lo} == '0, hi != '0);
                    end
                end
                DIV: begin
                    if (wb == '0) begin
                        F    <= '1;
                        F_hi <= wa;
                        flag <= pack_flag(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    end else if (cnt != LAST) begin
                        hi  <= div_ge ? div_sub : div_tmp[WIDTH-1:0];
                        lo  <= {lo[WIDTH-2:0], div_ge};
                        cnt <= cnt + CW'(1);
                    end else begin
                        F    <= lo;
                        F_hi <= hi;
                        flag <= pack_flag(1'b0, 1'b0, 1'b0, lo == '0, 1'b0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results queued at start, checked when done pulses.
module tb_alu_mc;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  data = '0;
    logic          LDDR1 = 1'b0, LDDR2 = 1'b0, LDCN = 1'b0;
    logic [3:0]    S = '0;
    logic          M = 1'b0;
    logic [1:0]    mode = '0;
    logic          start = 1'b0;
    logic          busy, done, CN;
    logic [W-1:0]  F, F_hi, A, B;
    logic [15:0]   flag;

    alu_mc #(.WIDTH(W), .FLAG_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .LDDR1(LDDR1), .LDDR2(LDDR2), .LDCN(LDCN),
        .S(S), .M(M), .mode(mode), .start(start), .busy(busy), .done(done),
        .F(F), .F_hi(F_hi), .flag(flag), .A(A), .B(B), .CN(CN)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned start_cyc;
        int unsigned lat;
        logic [15:0] f;
        logic [15:0] fhi;
        logic [15:0] flg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                check("F", F, mon_e.f);
                check("F_hi", F_hi, mon_e.fhi);
                check("flag", flag, mon_e.flg);
                check("latency", cyc - mon_e.start_cyc, mon_e.lat);
            end
        end
    end

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cn,
                                   input logic [3:0] s, input logic m, input logic [1:0] md);
        exp_t e;
        logic [31:0] p;
        logic [16:0] s17;
        int          si;
        logic        cy, v;
        e.start_cyc = 0;
        e.fhi = 16'h0;
        if (md == 2'b01) begin
            p = 32'(a) * 32'(b);
            e.f = p[15:0];
            e.fhi = p[31:16];
            e.flg = {14'h0, p == 0, p[31:16] != 0};
            e.lat = 18;
        end else if (md == 2'b10) begin
            if (b == 0) begin
                e.f = 16'hFFFF;
                e.fhi = a;
                e.flg = 16'h0010;
                e.lat = 2;
            end else begin
                e.f = a / b;
                e.fhi = a % b;
                e.flg = {14'h0, (a / b) == 0, 1'b0};
                e.lat = 18;
            end
        end else begin
            cy = 1'b0;
            v = 1'b0;
            e.f = 16'h0;
            if (!m && s == 4'b1001) begin
                s17 = {1'b0, a} + {1'b0, b} + {16'h0, cn};
                e.f = s17[15:0];
                cy = s17[16];
                si = int'($signed(a)) + int'($signed(b)) + int'(cn);
                v = (si > 32767) || (si < -32768);
            end else if (!m && s == 4'b0110) begin
                s17 = {1'b0, a} + {1'b0, ~b} + {16'h0, cn};
                e.f = s17[15:0];
                cy = s17[16];
                si = int'($signed(a)) - int'($signed(b)) - 1 + int'(cn);
                v = (si > 32767) || (si < -32768);
            end else if (m && s == 4'b1011) e.f = a & b;
            else if (m && s == 4'b1110) e.f = a | b;
            else if (m && s == 4'b0110) e.f = a ^ b;
            e.flg = {11'h0, 1'b0, v, e.f[15], e.f == 0, cy};
            e.lat = 2;
        end
        return e;
    endfunction

    task automatic load_ops(input logic [15:0] a, input logic [15:0] b, input logic cn);
        @(negedge clk); data = a; LDDR1 = 1'b1;
        @(negedge clk); LDDR1 = 1'b0; data = b; LDDR2 = 1'b1;
        @(negedge clk); LDDR2 = 1'b0; data = {15'h0, cn}; LDCN = 1'b1;
        @(negedge clk); LDCN = 1'b0;
        check("A_load", A, a);
        check("B_load", B, b);
        check("CN_load", CN, cn);
    endtask

    task automatic start_op(input logic [3:0] s, input logic m, input logic [1:0] md,
                            input logic [15:0] f, input logic [15:0] fhi,
                            input logic [15:0] flg, input int unsigned lat);
        exp_t e;
        @(negedge clk);
        S = s; M = m; mode = md; start = 1'b1;
        e.start_cyc = cyc; e.lat = lat; e.f = f; e.fhi = fhi; e.flg = flg;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_model(input logic [15:0] a, input logic [15:0] b, input logic cn,
                             input logic [3:0] s, input logic m, input logic [1:0] md);
        exp_t e;
        e = model(a, b, cn, s, m, md);
        load_ops(a, b, cn);
        start_op(s, m, md, e.f, e.fhi, e.flg, e.lat);
        wait_empty();
    endtask

    logic [3:0] rs;
    logic       rm;
    logic [1:0] rmd;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_CN", CN, 0);
        check("rst_F", F, 0);
        check("rst_F_hi", F_hi, 0);
        check("rst_flag", flag, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        // ALU cases with hand-derived expectations
        load_ops(16'h7FFF, 16'h0001, 1'b0);
        start_op(4'b1001, 1'b0, 2'b00, 16'h8000, 16'h0000, 16'h000C, 2); wait_empty();
        load_ops(16'hFFFF, 16'h0001, 1'b0);
        start_op(4'b1001, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0003, 2); wait_empty();
        load_ops(16'hFFFF, 16'h0001, 1'b1);
        start_op(4'b1001, 1'b0, 2'b00, 16'h0001, 16'h0000, 16'h0001, 2); wait_empty();
        load_ops(16'h0005, 16'h0003, 1'b1);
        start_op(4'b0110, 1'b0, 2'b00, 16'h0002, 16'h0000, 16'h0001, 2); wait_empty();
        load_ops(16'hF0F0, 16'hFF00, 1'b0);
        start_op(4'b1011, 1'b1, 2'b00, 16'hF000, 16'h0000, 16'h0004, 2); wait_empty();
        start_op(4'b1110, 1'b1, 2'b00, 16'hFFF0, 16'h0000, 16'h0004, 2); wait_empty();
        start_op(4'b0110, 1'b1, 2'b00, 16'h0FF0, 16'h0000, 16'h0000, 2); wait_empty();

        // Divide, including divide-by-zero
        load_ops(16'd1000, 16'd7, 1'b0);
        start_op(4'b0000, 1'b0, 2'b10, 16'h008E, 16'h0006, 16'h0000, 18); wait_empty();
        load_ops(16'h0055, 16'h0000, 1'b0);
        start_op(4'b0000, 1'b0, 2'b10, 16'hFFFF, 16'h0055, 16'h0010, 2); wait_empty();

        // Multiply with an operand load attempted while busy
        load_ops(16'h1234, 16'h0100, 1'b0);
        start_op(4'b0000, 1'b0, 2'b01, 16'h3400, 16'h0012, 16'h0001, 18);
        repeat (3) @(negedge clk);
        check("mul_busy", busy, 1);
        data = 16'hBEEF; LDDR1 = 1'b1; LDDR2 = 1'b1;
        @(negedge clk); LDDR1 = 1'b0; LDDR2 = 1'b0;
        wait_empty();
        check("A_held", A, 16'h1234);
        check("B_held", B, 16'h0100);

        // Random operations against the model
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 6))
                0: begin rs = 4'b1001; rm = 1'b0; rmd = 2'b00; end
                1: begin rs = 4'b0110; rm = 1'b0; rmd = 2'b00; end
                2: begin rs = 4'b1011; rm = 1'b1; rmd = 2'b00; end
                3: begin rs = 4'b1110; rm = 1'b1; rmd = 2'b11; end
                4: begin rs = 4'b0110; rm = 1'b1; rmd = 2'b00; end
                5: begin rs = 4'b0000; rm = 1'b0; rmd = 2'b01; end
                default: begin rs = 4'b0000; rm = 1'b0; rmd = 2'b10; end
            endcase
            run_model(16'($urandom), 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom),
                      1'($urandom), rs, rm, rmd);
        end

        // Asynchronous reset during the fifth multiply cycle
        load_ops(16'h1234, 16'h0100, 1'b0);
        start_op(4'b0000, 1'b0, 2'b01, 16'h3400, 16'h0012, 16'h0001, 18);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_busy", busy, 0);
        check("arst_F", F, 0);
        check("arst_A", A, 0);
        check("arst_flag", flag, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_busy", busy, 0);
        load_ops(16'h0021, 16'h0010, 1'b0);
        start_op(4'b1001, 1'b0, 2'b00, 16'h0031, 16'h0000, 16'h0000, 2); wait_empty();

        // Load in the same cycle as start does not affect that operation
        load_ops(16'h0002, 16'h0001, 1'b0);
        begin
            exp_t e;
            @(negedge clk);
            data = 16'h0003; LDDR1 = 1'b1; S = 4'b1001; M = 1'b0; mode = 2'b00; start = 1'b1;
            e.start_cyc = cyc; e.lat = 2; e.f = 16'h0003; e.fhi = 16'h0000; e.flg = 16'h0000;
            sb.push_back(e);
            @(negedge clk);
            LDDR1 = 1'b0; start = 1'b0;
        end
        wait_empty();
        check("A_same_cycle", A, 16'h0003);

        // start while in DONE is ignored
        load_ops(16'h0100, 16'h0200, 1'b0);
        start_op(4'b1001, 1'b0, 2'b00, 16'h0300, 16'h0000, 16'h0000, 2);
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_seen", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", busy, 0);
        repeat (6) @(negedge clk);
        check("restart_idle", busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
